// File: rtl/slot_pkg.sv
// Shared types for the slot machine: reel width, result encoding,
// round-controller states and the latched-reel payload.
package slot_pkg;

    localparam int unsigned NBITS_COUNT = 4;

    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_PAIR   = 2'b01,
        RES_TRIPLE = 2'b10
    } result_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SPIN = 3'd1,
        EVAL = 3'd2,
        PAY  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [NBITS_COUNT-1:0] r3;
        logic [NBITS_COUNT-1:0] r2;
        logic [NBITS_COUNT-1:0] r1;
    } reels_t;

endpackage

// File: rtl/slot_judge_if.sv
// Reel/lock inputs and judge outputs of the slot round controller.
// Optional SLOT_JUDGE_STATS_EN adds the jackpots counter.
interface slot_judge_if
    import slot_pkg::*;
#(
    parameter int unsigned NBITS_CREDIT = 8
);
    logic [NBITS_COUNT-1:0]  reel1;
    logic [NBITS_COUNT-1:0]  reel2;
    logic [NBITS_COUNT-1:0]  reel3;
    logic [2:0]              lock;
    logic [NBITS_CREDIT-1:0] credits;
    result_t                 result;
    logic                    result_valid;
    logic                    busy;
    logic                    no_credit;
`ifdef SLOT_JUDGE_STATS_EN
    logic [7:0]              jackpots;
`endif

    modport master (
        output reel1, reel2, reel3, lock,
        input  credits, result, result_valid, busy, no_credit
`ifdef SLOT_JUDGE_STATS_EN
        , input jackpots
`endif
    );

    modport slave (
        input  reel1, reel2, reel3, lock,
        output credits, result, result_valid, busy, no_credit
`ifdef SLOT_JUDGE_STATS_EN
        , output jackpots
`endif
    );

endinterface

// File: rtl/slot_match.sv
// Combinational classifier: triple, pair or nothing for three reel values.
module slot_match
    import slot_pkg::*;
(
    input  logic [NBITS_COUNT-1:0] r1,
    input  logic [NBITS_COUNT-1:0] r2,
    input  logic [NBITS_COUNT-1:0] r3,
    output result_t                res_c
);

    logic eq12_c, eq23_c, eq13_c;

    assign eq12_c = (r1 == r2);
    assign eq23_c = (r2 == r3);
    assign eq13_c = (r1 == r3);

    always_comb begin
        res_c = RES_NONE;
        if (eq12_c && eq23_c)
            res_c = RES_TRIPLE;
        else if (eq12_c || eq23_c || eq13_c)
            res_c = RES_PAIR;
    end

endmodule

// File: rtl/slot_judge.sv
// Slot round controller: charges the bet, latches locked reels, pays the prize
// one credit per cycle. Optional SLOT_JUDGE_STATS_EN adds a jackpots counter.
module slot_judge
    import slot_pkg::*;
#(
    parameter int unsigned NBITS_CREDIT = 8,
    parameter int unsigned CREDIT_INIT  = 10,
    parameter int unsigned BET          = 1,
    parameter int unsigned PRIZE_PAIR   = 2,
    parameter int unsigned PRIZE_TRIPLE = 10
) (
    input  logic          clk_2,
    input  logic          reset,
    slot_judge_if.slave   bus
);

    localparam int unsigned NBITS_PAYOUT = 8;
    localparam logic [NBITS_CREDIT-1:0] CREDIT_MAX = '1;

    state_t                  state, state_next;
    logic [NBITS_CREDIT-1:0] credits;
    logic [NBITS_PAYOUT-1:0] payout;
    reels_t                  reels_q;
    result_t                 result_q;
    result_t                 match_c;
    logic                    result_valid_q;
    logic                    busy_q;

    logic                    lock_none_c, lock_all_c, can_bet_c;
    logic                    charge_c, latch_c, eval_c, pay_c;
    logic [NBITS_PAYOUT-1:0] prize_c;

    assign lock_none_c = ~|bus.lock;
    assign lock_all_c  = &bus.lock;
    assign can_bet_c   = (credits >= NBITS_CREDIT'(BET));

    slot_match u_match (
        .r1    (reels_q.r1),
        .r2    (reels_q.r2),
        .r3    (reels_q.r3),
        .res_c (match_c)
    );

    // State register
    always_ff @(posedge clk_2) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (lock_none_c && can_bet_c) state_next = SPIN;
            SPIN: if (lock_all_c)               state_next = EVAL;
            EVAL: state_next = (prize_c != '0) ? PAY : DONE;
            PAY:  if (payout == NBITS_PAYOUT'(1)) state_next = DONE;
            DONE: if (lock_none_c)              state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath strobes and prize decode
    always_comb begin
        charge_c = 1'b0;
        latch_c  = 1'b0;
        eval_c   = 1'b0;
        pay_c    = 1'b0;
        prize_c  = '0;
        case (match_c)
            RES_PAIR:   prize_c = NBITS_PAYOUT'(PRIZE_PAIR);
            RES_TRIPLE: prize_c = NBITS_PAYOUT'(PRIZE_TRIPLE);
            default:    prize_c = '0;
        endcase
        case (state)
            IDLE:    charge_c = lock_none_c && can_bet_c;
            SPIN:    latch_c  = lock_all_c;
            EVAL:    eval_c   = 1'b1;
            PAY:     pay_c    = 1'b1;
            default: ;
        endcase
    end

    // Credits, latched reels, result and payout countdown
    always_ff @(posedge clk_2) begin
        if (reset) begin
            credits        <= NBITS_CREDIT'(CREDIT_INIT);
            payout         <= '0;
            reels_q        <= '0;
            result_q       <= RES_NONE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            if (charge_c)
                credits <= credits - NBITS_CREDIT'(BET);
            else if (pay_c && (credits != CREDIT_MAX))
                credits <= credits + NBITS_CREDIT'(1);

            if (latch_c)
                reels_q <= '{r3: bus.reel3, r2: bus.reel2, r1: bus.reel1};

            if (eval_c) begin
                result_q <= match_c;
                payout   <= prize_c;
            end else if (pay_c) begin
                payout   <= payout - NBITS_PAYOUT'(1);
            end

            result_valid_q <= (state == DONE);
            busy_q         <= (state == EVAL) || (state == PAY);
        end
    end

`ifdef SLOT_JUDGE_STATS_EN
    logic [7:0] jackpots_q;

    // Saturating count of triples
    always_ff @(posedge clk_2) begin
        if (reset)
            jackpots_q <= '0;
        else if (eval_c && (match_c == RES_TRIPLE) && (jackpots_q != 8'hFF))
            jackpots_q <= jackpots_q + 8'd1;
    end

    assign bus.jackpots = jackpots_q;
`endif

    assign bus.credits      = credits;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.no_credit    = ~can_bet_c;

endmodule

// File: tb/tb_slot_judge.sv
// Randomized self-checking bench for slot_judge against a round-level model.
module tb_slot_judge;
    import slot_pkg::*;

    localparam int BET  = 1;
    localparam int CMAX = 255;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       sel   = 1'b0;
    logic [3:0] reel1 = '0, reel2 = '0, reel3 = '0;
    logic [2:0] lock  = 3'b001;

    int n_checks = 0;
    int n_errors = 0;
    int m_credits = 10;
    int m_init    = 10;
    int m_jack    = 0;
    bit in_done   = 0;

    slot_judge_if #(.NBITS_CREDIT(8)) bus_a ();
    slot_judge_if #(.NBITS_CREDIT(8)) bus_b ();

    slot_judge #(.CREDIT_INIT(10))  dut    (.clk_2(clk_2), .reset(reset), .bus(bus_a.slave));
    slot_judge #(.CREDIT_INIT(250)) dut_hi (.clk_2(clk_2), .reset(reset), .bus(bus_b.slave));

    always #5 clk_2 = ~clk_2;

    assign bus_a.reel1 = reel1;
    assign bus_a.reel2 = reel2;
    assign bus_a.reel3 = reel3;
    assign bus_b.reel1 = reel1;
    assign bus_b.reel2 = reel2;
    assign bus_b.reel3 = reel3;
    assign bus_a.lock  = sel ? 3'b001 : lock;
    assign bus_b.lock  = sel ? lock : 3'b001;

    logic [7:0] o_credits;
    logic [1:0] o_result;
    logic       o_rv, o_busy, o_nc;
    assign o_credits = sel ? bus_b.credits      : bus_a.credits;
    assign o_result  = sel ? bus_b.result       : bus_a.result;
    assign o_rv      = sel ? bus_b.result_valid : bus_a.result_valid;
    assign o_busy    = sel ? bus_b.busy         : bus_a.busy;
    assign o_nc      = sel ? bus_b.no_credit    : bus_a.no_credit;
`ifdef SLOT_JUDGE_STATS_EN
    logic [7:0] o_jack;
    assign o_jack = sel ? bus_b.jackpots : bus_a.jackpots;
`endif

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    // 2 = triple, 1 = pair, 0 = none, from the number of equal reel pairs
    function automatic int classify(input int a, input int b, input int c);
        int eq;
        eq = int'(a == b) + int'(b == c) + int'(a == c);
        if (eq == 3) return 2;
        if (eq == 1) return 1;
        return 0;
    endfunction

    function automatic int prize_of(input int cls);
        return (cls == 2) ? 10 : (cls == 1) ? 2 : 0;
    endfunction

    task automatic set_reels(input int a, input int b, input int c);
        reel1 = 4'(a);
        reel2 = 4'(b);
        reel3 = 4'(c);
    endtask

    task automatic do_reset(input int init);
        reset = 1'b1;
        lock  = 3'b001;
        tick();
        tick();
        reset     = 1'b0;
        m_init    = init;
        m_credits = init;
        m_jack    = 0;
        in_done   = 0;
    endtask

    task automatic check_jack(input string tag);
`ifdef SLOT_JUDGE_STATS_EN
        chk(tag, int'(o_jack), m_jack);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // One full round; rst_k > 0 asserts reset during that PAY cycle instead of finishing
    task automatic play_round(input int a, input int b, input int c, input int rst_k);
        int cls, prize, start;
        lock = 3'b000;
        if (in_done) begin
            tick();
            in_done = 0;
        end
        if (m_credits < BET) begin
            for (int i = 0; i < 8; i++) begin
                tick();
                chk("nocred_flag", int'(o_nc), 1);
                chk("nocred_credits", int'(o_credits), m_credits);
                chk("nocred_busy", int'(o_busy), 0);
            end
            lock = 3'b001;
            return;
        end
        tick();
        m_credits -= BET;
        chk("bet_credits", int'(o_credits), m_credits);
        chk("spin_rv", int'(o_rv), 0);
        chk("spin_nc", int'(o_nc), int'(m_credits < BET));

        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            lock = 3'($urandom_range(0, 6));
            set_reels(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            tick();
            chk("spin_hold_credits", int'(o_credits), m_credits);
            chk("spin_busy", int'(o_busy), 0);
        end

        set_reels(a, b, c);
        lock = 3'b111;
        tick();                                   // edge E
        set_reels(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        tick();                                   // edge E+1
        cls   = classify(a, b, c);
        prize = prize_of(cls);
        start = m_credits;
        chk("eval_result", int'(o_result), cls);
        chk("eval_busy", int'(o_busy), 1);
        chk("eval_rv", int'(o_rv), 0);
        if (cls == 2 && m_jack < 255) m_jack++;

        for (int k = 1; k <= prize; k++) begin
            if (k == rst_k) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                m_credits = m_init;
                m_jack    = 0;
                chk("rst_credits", int'(o_credits), m_credits);
                chk("rst_result", int'(o_result), 0);
                chk("rst_rv", int'(o_rv), 0);
                chk("rst_busy", int'(o_busy), 0);
                check_jack("rst_jackpots");
                lock = 3'b000;
                tick();
                m_credits -= BET;
                chk("rst_idle_bet", int'(o_credits), m_credits);
                lock = 3'b001;
                return;
            end
            tick();
            m_credits = (start + k > CMAX) ? CMAX : start + k;
            chk("pay_credits", int'(o_credits), m_credits);
            chk("pay_busy", int'(o_busy), 1);
            chk("pay_rv", int'(o_rv), 0);
        end

        tick();                                   // edge E+2+P
        chk("done_rv", int'(o_rv), 1);
        chk("done_busy", int'(o_busy), 0);
        chk("done_credits", int'(o_credits), m_credits);
        chk("done_result", int'(o_result), cls);
        check_jack("done_jackpots");

        lock = 3'b010;
        tick();
        tick();
        chk("partial_release_rv", int'(o_rv), 1);
        chk("partial_release_result", int'(o_result), cls);
        chk("partial_release_credits", int'(o_credits), m_credits);
        in_done = 1;
    endtask

    initial begin
        int x, y, mode, pos;

        do_reset(10);
        chk("reset_credits", int'(o_credits), 10);
        chk("reset_result", int'(o_result), 0);
        chk("reset_rv", int'(o_rv), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_nc", int'(o_nc), 0);
        check_jack("reset_jackpots");

        play_round(3, 3, 3, 0);
        play_round(1, 4, 1, 0);
        play_round(0, 2, 5, 0);

        for (int r = 0; r < 20; r++) begin
            mode = int'($urandom_range(0, 2));
            x    = int'($urandom_range(0, 15));
            y    = (x + 1 + int'($urandom_range(0, 14))) % 16;
            pos  = int'($urandom_range(0, 2));
            if (mode == 0)
                play_round(x, x, x, 0);
            else if (mode == 1)
                play_round(pos == 0 ? y : x, pos == 1 ? y : x, pos == 2 ? y : x, 0);
            else
                play_round(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 15)), 0);
        end

        // Drain with losing rounds, then attempt a spin with no credit
        for (int i = 0; i < 300 && m_credits >= BET; i++) begin
            x = int'($urandom_range(0, 13));
            play_round(x, x + 1, x + 2, 0);
        end
        chk("drained_credits", int'(o_credits), 0);
        play_round(1, 1, 1, 0);

        do_reset(10);
        play_round(7, 7, 7, 4);

        sel = 1'b1;
        do_reset(250);
        chk("hi_reset_credits", int'(o_credits), 250);
        play_round(5, 5, 5, 0);
        chk("hi_saturated", int'(o_credits), 255);
        play_round(2, 9, 2, 0);
        play_round(1, 2, 3, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
